// File: rtl/stream_demux_1xn.sv
// stream_demux_1xn: registered 1-to-N valid/ready demultiplexer with broadcast and drop counting
module stream_demux_1xn #(
    parameter int DATA_W = 8,
    parameter int N_OUT = 4,
    localparam int SEL_W = $clog2(N_OUT)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_W-1:0]       in_data,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic                    in_bcast,
    output logic [N_OUT-1:0]        out_valid,
    input  logic [N_OUT-1:0]        out_ready,
    output logic [N_OUT*DATA_W-1:0] out_data,
    output logic [7:0]              drop_cnt
);
    logic [N_OUT-1:0] ch_free;
    logic [N_OUT-1:0] load;
    logic             sel_bad;
    logic             acc;

    // A slot can take a word if empty or draining this edge; bad selects are always swallowed
    always_comb begin
        ch_free = ~out_valid | out_ready;
        sel_bad = (32'(in_sel) >= N_OUT) && !in_bcast;
        in_ready = in_bcast ? &ch_free : sel_bad ? 1'b1 : ch_free[in_sel];
        acc = in_valid && in_ready;
        for (int k = 0; k < N_OUT; k++)
            load[k] = acc && !sel_bad && (in_bcast || 32'(in_sel) == k);
    end

    // Per-channel one-entry slot: reload wins over drain so full throughput is kept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= '0;
            out_data <= '0;
        end else begin
            for (int k = 0; k < N_OUT; k++) begin
                if (load[k]) begin
                    out_valid[k] <= 1'b1;
                    out_data[k*DATA_W +: DATA_W] <= in_data;
                end else if (out_ready[k]) begin
                    out_valid[k] <= 1'b0;
                end
            end
        end
    end

    // Saturating count of words discarded for an out-of-range select
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            drop_cnt <= '0;
        else if (acc && sel_bad && drop_cnt != 8'hff)
            drop_cnt <= drop_cnt + 8'd1;
    end
endmodule

// File: tb/tb_stream_demux_1xn.sv
// tb_stream_demux_1xn: randomized scoreboard bench for stream_demux_1xn with N_OUT=5
module tb_stream_demux_1xn;
    localparam int DW = 8;
    localparam int N = 5;
    localparam int SW = 3;

    logic          clk = 0;
    logic          rst_n = 0;
    logic          in_valid = 0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic [SW-1:0] in_sel = '0;
    logic          in_bcast = 0;
    logic [N-1:0]  out_valid;
    logic [N-1:0]  out_ready = '0;
    logic [N*DW-1:0] out_data;
    logic [7:0]    drop_cnt;

    stream_demux_1xn #(.DATA_W(DW), .N_OUT(N)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_sel(in_sel), .in_bcast(in_bcast),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    logic [DW-1:0] q[N][$];
    int drop_m = 0;
    bit acc_last = 1;
    bit p_stall = 0;
    logic [DW+SW:0] p_word;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: each slot must match the head of its expected queue; a drain pops it
    always @(negedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < N; k++) begin
                chk($sformatf("out_valid[%0d]", k), 64'(out_valid[k]), 64'(q[k].size() != 0));
                if (out_valid[k] && q[k].size() != 0) begin
                    chk($sformatf("out_data[%0d]", k), 64'(out_data[k*DW +: DW]), 64'(q[k][0]));
                    if (out_ready[k]) void'(q[k].pop_front());
                end
            end
            chk("drop_cnt", 64'(drop_cnt), 64'(drop_m));
        end
    end

    // Scoreboard input side: predict in_ready from slot occupancy and record accepted words
    always @(negedge clk) begin
        bit exp_r;
        bit bad;
        #1;
        if (!rst_n) begin
            for (int k = 0; k < N; k++) q[k].delete();
            drop_m = 0;
            acc_last = 1;
            p_stall = 0;
        end else begin
            if (p_stall)
                chk("upstream_hold", 64'({in_valid, in_bcast, in_sel, in_data}), 64'({1'b1, p_word}));
            bad = !in_bcast && int'(in_sel) >= N;
            if (in_bcast) begin
                exp_r = 1;
                for (int k = 0; k < N; k++) if (q[k].size() != 0) exp_r = 0;
            end else if (bad) begin
                exp_r = 1;
            end else begin
                exp_r = q[in_sel].size() == 0;
            end
            chk("in_ready", 64'(in_ready), 64'(exp_r));
            acc_last = in_valid && exp_r;
            p_stall = in_valid && !exp_r;
            p_word = {in_bcast, in_sel, in_data};
            if (acc_last) begin
                if (in_bcast) for (int k = 0; k < N; k++) q[k].push_back(in_data);
                else if (bad) drop_m = drop_m < 255 ? drop_m + 1 : 255;
                else q[in_sel].push_back(in_data);
            end
        end
    end

    task automatic step(bit v, logic [DW-1:0] d, logic [SW-1:0] s, bit b, logic [N-1:0] r);
        @(posedge clk);
        #1;
        out_ready = r;
        if (!(in_valid && !acc_last)) begin
            in_valid = v;
            in_data = d;
            in_sel = s;
            in_bcast = b;
        end
    endtask

    task automatic rand_step();
        logic [N-1:0] r;
        for (int k = 0; k < N; k++) r[k] = $urandom_range(0, 9) < 7;
        step($urandom_range(0, 3) != 0, DW'($urandom), SW'($urandom_range(0, 7)),
             $urandom_range(0, 7) == 0, r);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #2;
        chk("reset_out_valid", 64'(out_valid), 0);
        chk("reset_out_data", 64'(out_data), 0);
        chk("reset_drop_cnt", 64'(drop_cnt), 0);
        #1 rst_n = 1;
        step(1, 8'hA5, 2, 0, '1);
        repeat (3) step(0, 0, 0, 0, '1);
        step(1, 8'h11, 1, 0, 5'b11101);
        step(1, 8'h12, 1, 0, 5'b11101);
        step(1, 8'h12, 1, 0, 5'b11101);
        repeat (4) step(0, 0, 0, 0, '1);
        step(1, 8'h77, 0, 0, 5'b11110);
        step(1, 8'h3C, 0, 1, 5'b11110);
        step(1, 8'h3C, 0, 1, 5'b11110);
        repeat (4) step(0, 0, 0, 0, '1);
        repeat (3000) rand_step();
        repeat (300) step(1, DW'($urandom), 6, 0, '1);
        repeat (3) step(0, 0, 0, 0, '1);
        @(negedge clk);
        chk("drop_saturated", 64'(drop_cnt), 255);
        for (int i = 0; i < 20; i++) step(1, DW'(i * 7 + 1), 0, 0, '1);
        step(1, 8'hE1, 0, 1, '0);
        step(1, 8'hE2, 3, 0, '0);
        step(1, 8'hE3, 6, 0, '0);
        #3 rst_n = 0;
        #1;
        chk("async_rst_out_valid", 64'(out_valid), 0);
        chk("async_rst_out_data", 64'(out_data), 0);
        chk("async_rst_drop_cnt", 64'(drop_cnt), 0);
        in_valid = 0;
        @(posedge clk);
        #3 rst_n = 1;
        step(1, 8'h5A, 4, 0, '1);
        repeat (500) rand_step();
        repeat (6) step(0, 0, 0, 0, '1);
        @(negedge clk);
        #2;
        for (int k = 0; k < N; k++) chk($sformatf("drained[%0d]", k), 64'(q[k].size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
